// File: rtl/risc_v_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, funct fields,
// FSM states, instruction classes and the ALU/immediate/write-back select codes.
package risc_v_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_R       = 4'd1,
    CLS_I       = 4'd2,
    CLS_LOAD    = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_JALR    = 4'd7,
    CLS_LUI     = 4'd8,
    CLS_AUIPC   = 4'd9
  } inst_class_t;

  localparam logic [3:0] ALU_SEL_ADD    = 4'd0;
  localparam logic [3:0] ALU_SEL_SUB    = 4'd1;
  localparam logic [3:0] ALU_SEL_XOR    = 4'd2;
  localparam logic [3:0] ALU_SEL_OR     = 4'd3;
  localparam logic [3:0] ALU_SEL_AND    = 4'd4;
  localparam logic [3:0] ALU_SEL_SLL    = 4'd5;
  localparam logic [3:0] ALU_SEL_SRL    = 4'd6;
  localparam logic [3:0] ALU_SEL_SRA    = 4'd7;
  localparam logic [3:0] ALU_SEL_SLT    = 4'd8;
  localparam logic [3:0] ALU_SEL_SLTU   = 4'd9;
  localparam logic [3:0] ALU_SEL_PASS_B = 4'd10;

  localparam logic [2:0] IMM_SEL_R = 3'd0;
  localparam logic [2:0] IMM_SEL_I = 3'd1;
  localparam logic [2:0] IMM_SEL_S = 3'd2;
  localparam logic [2:0] IMM_SEL_B = 3'd3;
  localparam logic [2:0] IMM_SEL_U = 3'd4;
  localparam logic [2:0] IMM_SEL_J = 3'd5;

  localparam logic [1:0] WB_SEL_MEM = 2'b00;
  localparam logic [1:0] WB_SEL_ALU = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  // alt selects SUB for funct3=000 and SRA for funct3=101; ignored otherwise
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SEL_SUB : ALU_SEL_ADD;
      F3_SLL:     op = ALU_SEL_SLL;
      F3_SLT:     op = ALU_SEL_SLT;
      F3_SLTU:    op = ALU_SEL_SLTU;
      F3_XOR:     op = ALU_SEL_XOR;
      F3_SRL_SRA: op = alt ? ALU_SEL_SRA : ALU_SEL_SRL;
      F3_OR:      op = ALU_SEL_OR;
      F3_AND:     op = ALU_SEL_AND;
      default:    op = ALU_SEL_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational RV32I decoder: classifies the held IR, picks the immediate format
// and ALU operation, and flags encodings outside the supported integer set.
module inst_decoder
  import risc_v_ctrl_pkg::*;
#(
  parameter int INST_WIDTH = 32
) (
  input  logic [INST_WIDTH-1:0] ir,
  output inst_class_t           inst_class,
  output logic [2:0]            imm_sel,
  output logic [3:0]            alu_sel,
  output logic                  legal
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       unused_fields_s;

  assign opcode_s = ir[6:0];
  assign funct3_s = ir[14:12];
  assign funct7_s = ir[31:25];
  // register and immediate fields are consumed by the datapath's own IR copy
  assign unused_fields_s = ^ir[24:7];

  // Opcode/funct decode into class, immediate format, ALU op and legality
  always_comb begin
    inst_class = CLS_ILLEGAL;
    imm_sel    = IMM_SEL_R;
    alu_sel    = ALU_SEL_ADD;
    legal      = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        inst_class = CLS_R;
        alu_sel    = alu_from_funct3(funct3_s, funct7_s == F7_ALT);
        if (funct7_s == F7_BASE) begin
          legal = 1'b1;
        end else if (funct7_s == F7_ALT) begin
          legal = (funct3_s == F3_ADD_SUB) || (funct3_s == F3_SRL_SRA);
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        inst_class = CLS_I;
        imm_sel    = IMM_SEL_I;
        alu_sel    = alu_from_funct3(funct3_s, (funct3_s == F3_SRL_SRA) && (funct7_s == F7_ALT));
        case (funct3_s)
          F3_SLL:     legal = (funct7_s == F7_BASE);
          F3_SRL_SRA: legal = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
          default:    legal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        inst_class = CLS_LOAD;
        imm_sel    = IMM_SEL_I;
        case (funct3_s)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
          default:                             legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        inst_class = CLS_STORE;
        imm_sel    = IMM_SEL_S;
        case (funct3_s)
          F3_SB, F3_SH, F3_SW: legal = 1'b1;
          default:             legal = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        inst_class = CLS_BRANCH;
        imm_sel    = IMM_SEL_B;
        case (funct3_s)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: legal = 1'b1;
          default:                                         legal = 1'b0;
        endcase
      end
      OPC_JAL: begin
        inst_class = CLS_JAL;
        imm_sel    = IMM_SEL_J;
        legal      = 1'b1;
      end
      OPC_JALR: begin
        inst_class = CLS_JALR;
        imm_sel    = IMM_SEL_I;
        legal      = (funct3_s == F3_JALR);
      end
      OPC_LUI: begin
        inst_class = CLS_LUI;
        imm_sel    = IMM_SEL_U;
        alu_sel    = ALU_SEL_PASS_B;
        legal      = 1'b1;
      end
      OPC_AUIPC: begin
        inst_class = CLS_AUIPC;
        imm_sel    = IMM_SEL_U;
        legal      = 1'b1;
      end
      default: begin
        inst_class = CLS_ILLEGAL;
        legal      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory handshakes.
// Optional retired-instruction counter port `instret` enabled by defining CTRL_INSTRET_EN.
module multicycle_control_fsm
  import risc_v_ctrl_pkg::*;
#(
  parameter int INST_WIDTH    = 32,
  parameter int IMM_SEL_WIDTH = 3,
  parameter int ALU_SEL_WIDTH = 4,
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [INST_WIDTH-1:0]    inst,
  input  logic                     imem_ready,
  input  logic                     dmem_ready,
  input  logic                     br_eq,
  input  logic                     br_lt,
  output logic                     imem_req,
  output logic                     ir_write,
  output logic                     dmem_req,
  output logic                     mem_write,
  output logic                     pc_write,
  output logic                     pc_sel,
  output logic [IMM_SEL_WIDTH-1:0] imm_sel,
  output logic                     reg_write_en,
  output logic                     br_un,
  output logic                     a_sel,
  output logic                     b_sel,
  output logic [ALU_SEL_WIDTH-1:0] alu_sel,
  output logic [1:0]               wb_sel,
  output logic                     illegal_inst,
`ifdef CTRL_INSTRET_EN
  output logic [INSTRET_WIDTH-1:0] instret,
`endif
  output logic                     busy
);

  state_t                state_r;
  state_t                state_next_s;
  logic [INST_WIDTH-1:0] ir_r;

  inst_class_t dec_class_s;
  logic [2:0]  dec_imm_sel_s;
  logic [3:0]  dec_alu_sel_s;
  logic        dec_legal_s;

  logic        dp_a_sel_s;
  logic        dp_b_sel_s;
  logic        taken_s;
  logic        is_mem_s;
  logic        is_jump_s;

  logic        imem_req_s;
  logic        ir_write_s;
  logic        dmem_req_s;
  logic        mem_write_s;
  logic        pc_write_s;
  logic        pc_sel_s;
  logic [2:0]  imm_sel_s;
  logic        reg_write_en_s;
  logic        br_un_s;
  logic        a_sel_s;
  logic        b_sel_s;
  logic [3:0]  alu_sel_s;
  logic [1:0]  wb_sel_s;
  logic        illegal_s;
  logic        busy_s;

  inst_decoder #(
    .INST_WIDTH(INST_WIDTH)
  ) u_decoder (
    .ir        (ir_r),
    .inst_class(dec_class_s),
    .imm_sel   (dec_imm_sel_s),
    .alu_sel   (dec_alu_sel_s),
    .legal     (dec_legal_s)
  );

  // PC is operand A for PC-relative targets; everything but R-type uses the immediate
  assign dp_a_sel_s = (dec_class_s == CLS_BRANCH) || (dec_class_s == CLS_JAL) ||
                      (dec_class_s == CLS_AUIPC);
  assign dp_b_sel_s = (dec_class_s != CLS_R);
  assign is_mem_s   = (dec_class_s == CLS_LOAD) || (dec_class_s == CLS_STORE);
  assign is_jump_s  = (dec_class_s == CLS_JAL) || (dec_class_s == CLS_JALR);

  // Branch condition from the comparator flags
  always_comb begin
    case (ir_r[14:12])
      F3_BEQ:           taken_s = br_eq;
      F3_BNE:           taken_s = ~br_eq;
      F3_BLT, F3_BLTU:  taken_s = br_lt;
      F3_BGE, F3_BGEU:  taken_s = ~br_lt;
      default:          taken_s = 1'b0;
    endcase
  end

  // State and IR registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_FETCH;
      ir_r    <= '0;
    end else begin
      state_r <= state_next_s;
      if (ir_write_s) begin
        ir_r <= inst;
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next_s   = state_r;
    imem_req_s     = 1'b0;
    ir_write_s     = 1'b0;
    dmem_req_s     = 1'b0;
    mem_write_s    = 1'b0;
    pc_write_s     = 1'b0;
    pc_sel_s       = 1'b0;
    imm_sel_s      = IMM_SEL_R;
    reg_write_en_s = 1'b0;
    br_un_s        = 1'b0;
    a_sel_s        = 1'b0;
    b_sel_s        = 1'b0;
    alu_sel_s      = ALU_SEL_ADD;
    wb_sel_s       = WB_SEL_MEM;
    illegal_s      = 1'b0;
    busy_s         = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ready) begin
          ir_write_s   = 1'b1;
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        busy_s       = 1'b1;
        imm_sel_s    = dec_imm_sel_s;
        state_next_s = dec_legal_s ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        busy_s    = 1'b1;
        imm_sel_s = dec_imm_sel_s;
        a_sel_s   = dp_a_sel_s;
        b_sel_s   = dp_b_sel_s;
        alu_sel_s = dec_alu_sel_s;
        if (dec_class_s == CLS_BRANCH) begin
          br_un_s      = ir_r[13];
          pc_write_s   = 1'b1;
          pc_sel_s     = taken_s;
          state_next_s = ST_FETCH;
        end else if (is_mem_s) begin
          state_next_s = ST_MEM;
        end else begin
          state_next_s = ST_WB;
        end
      end
      ST_MEM: begin
        // ALU selects stay put so the datapath address remains stable across wait states
        busy_s      = 1'b1;
        imm_sel_s   = dec_imm_sel_s;
        a_sel_s     = dp_a_sel_s;
        b_sel_s     = dp_b_sel_s;
        alu_sel_s   = dec_alu_sel_s;
        dmem_req_s  = 1'b1;
        mem_write_s = (dec_class_s == CLS_STORE);
        if (!dmem_ready) begin
          state_next_s = ST_MEM;
        end else if (dec_class_s == CLS_STORE) begin
          pc_write_s   = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_WB;
        end
      end
      ST_WB: begin
        busy_s         = 1'b1;
        imm_sel_s      = dec_imm_sel_s;
        a_sel_s        = dp_a_sel_s;
        b_sel_s        = dp_b_sel_s;
        alu_sel_s      = dec_alu_sel_s;
        reg_write_en_s = 1'b1;
        pc_write_s     = 1'b1;
        pc_sel_s       = is_jump_s;
        if (dec_class_s == CLS_LOAD) begin
          wb_sel_s = WB_SEL_MEM;
        end else if (is_jump_s) begin
          wb_sel_s = WB_SEL_PC4;
        end else begin
          wb_sel_s = WB_SEL_ALU;
        end
        state_next_s = ST_FETCH;
      end
      ST_TRAP: begin
        illegal_s    = 1'b1;
        state_next_s = ST_TRAP;
      end
      default: begin
        state_next_s = ST_FETCH;
      end
    endcase
  end

  // reset_n forces every output low immediately, not just after the next edge
  assign imem_req     = reset_n & imem_req_s;
  assign ir_write     = reset_n & ir_write_s;
  assign dmem_req     = reset_n & dmem_req_s;
  assign mem_write    = reset_n & mem_write_s;
  assign pc_write     = reset_n & pc_write_s;
  assign pc_sel       = reset_n & pc_sel_s;
  assign imm_sel      = reset_n ? IMM_SEL_WIDTH'(imm_sel_s) : '0;
  assign reg_write_en = reset_n & reg_write_en_s;
  assign br_un        = reset_n & br_un_s;
  assign a_sel        = reset_n & a_sel_s;
  assign b_sel        = reset_n & b_sel_s;
  assign alu_sel      = reset_n ? ALU_SEL_WIDTH'(alu_sel_s) : '0;
  assign wb_sel       = reset_n ? wb_sel_s : 2'b00;
  assign illegal_inst = reset_n & illegal_s;
  assign busy         = reset_n & busy_s;

`ifdef CTRL_INSTRET_EN
  logic [INSTRET_WIDTH-1:0] instret_r;

  // Retired-instruction counter, one count per PC update, wraps naturally
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instret_r <= '0;
    end else if (pc_write) begin
      instret_r <= instret_r + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign instret = instret_r;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm; every expected value is hand-computed.
module tb_multicycle_control_fsm;
  import risc_v_ctrl_pkg::*;

  localparam logic [31:0] INST_ADD  = 32'h002081B3;
  localparam logic [31:0] INST_SUB  = 32'h402081B3;
  localparam logic [31:0] INST_LW   = 32'h0020A283;
  localparam logic [31:0] INST_SW   = 32'h0020A023;
  localparam logic [31:0] INST_BEQ  = 32'h00208063;
  localparam logic [31:0] INST_BGE  = 32'h0020D063;
  localparam logic [31:0] INST_BGEU = 32'h0020F063;
  localparam logic [31:0] INST_JAL  = 32'h000000EF;
  localparam logic [31:0] INST_BAD  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] inst;
  logic        imem_ready, dmem_ready, br_eq, br_lt;
  logic        imem_req, ir_write, dmem_req, mem_write, pc_write, pc_sel;
  logic [2:0]  imm_sel;
  logic        reg_write_en, br_un, a_sel, b_sel;
  logic [3:0]  alu_sel;
  logic [1:0]  wb_sel;
  logic        illegal_inst, busy;
`ifdef CTRL_INSTRET_EN
  logic [31:0] instret;
`endif

  logic [8:0]  strobes;
  int          n_checks = 0;
  int          n_fail = 0;
  int          pw_count = 0;
  int          both_req = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .inst(inst), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .br_eq(br_eq), .br_lt(br_lt),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req),
    .mem_write(mem_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .imm_sel(imm_sel), .reg_write_en(reg_write_en), .br_un(br_un),
    .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel), .wb_sel(wb_sel),
    .illegal_inst(illegal_inst),
`ifdef CTRL_INSTRET_EN
    .instret(instret),
`endif
    .busy(busy)
  );

  // order: imem_req ir_write dmem_req mem_write pc_write pc_sel reg_write_en illegal_inst busy
  assign strobes = {imem_req, ir_write, dmem_req, mem_write, pc_write, pc_sel,
                    reg_write_en, illegal_inst, busy};

  always @(negedge clk) begin
    if (!reset_n) begin
      pw_count <= 0;
    end else begin
      if (pc_write) pw_count <= pw_count + 1;
      if (imem_req && dmem_req) both_req <= both_req + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input logic [8:0] exp);
    n_checks++;
    assert (strobes === exp) else begin
      n_fail++;
      $error("FAIL %s: observed strobes %b expected %b", tag, strobes, exp);
    end
  endtask

  task automatic chk_st(input string tag, input state_t exp);
    n_checks++;
    assert (dut.state_r === exp) else begin
      n_fail++;
      $error("FAIL %s: observed state %0d expected %0d", tag, dut.state_r, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One FETCH cycle with a zero-wait imem; leaves the bench 1 time unit into DECODE
  task automatic run_fetch(input logic [31:0] word);
    inst = word;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    inst = INST_BAD;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; inst = 32'h0; imem_ready = 1'b0; dmem_ready = 1'b0;
    br_eq = 1'b0; br_lt = 1'b0;
    step(); step(); #1;
    chk_st("reset state", ST_FETCH);
    chk_s("reset outputs", 9'b000000000);
    reset_n = 1'b1; #1;
    chk_s("release fetch", 9'b100000000);

    step(); #1;
    chk_st("fetch wait state", ST_FETCH);
    chk_s("fetch wait strobes", 9'b100000000);

    // add x3,x1,x2: FETCH, DECODE, EXEC, WB
    inst = INST_ADD; imem_ready = 1'b1; #1;
    chk_s("add fetch", 9'b110000000);
    step(); inst = INST_BAD; imem_ready = 1'b0; #1;
    chk_st("add decode", ST_DECODE);
    chk_s("add decode strobes", 9'b000000001);
    chk("add decode imm_sel", 32'(imm_sel), 32'(IMM_SEL_R));
    step(); #1;
    chk_st("add exec", ST_EXEC);
    chk("add exec b_sel", 32'(b_sel), 32'd0);
    step(); #1;
    chk_st("add wb", ST_WB);
    chk_s("add wb strobes", 9'b000010101);
    chk("add wb_sel", 32'(wb_sel), 32'(WB_SEL_ALU));
    step(); #1;
    chk_st("add back to fetch", ST_FETCH);

    // sub: ALU op from funct7
    run_fetch(INST_SUB);
    step(); #1;
    chk("sub exec alu_sel", 32'(alu_sel), 32'(ALU_SEL_SUB));
    step(); step(); #1;
    chk_st("sub back to fetch", ST_FETCH);

    // lw with three dmem wait cycles: 8 cycles total
    run_fetch(INST_LW);
    chk("lw decode imm_sel", 32'(imm_sel), 32'(IMM_SEL_I));
    step(); #1;
    chk("lw exec a_sel", 32'(a_sel), 32'd0);
    chk("lw exec b_sel", 32'(b_sel), 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_s("lw mem wait", 9'b001000001);
      step();
    end
    dmem_ready = 1'b1; #1;
    chk_s("lw mem ready", 9'b001000001);
    step(); dmem_ready = 1'b0; #1;
    chk_st("lw wb", ST_WB);
    chk_s("lw wb strobes", 9'b000010101);
    chk("lw wb_sel", 32'(wb_sel), 32'(WB_SEL_MEM));
    step(); #1;
    chk_st("lw back to fetch at cycle 8", ST_FETCH);

    // sw with zero-wait dmem: 4 cycles, retires from MEM
    dmem_ready = 1'b1;
    run_fetch(INST_SW);
    chk("sw decode imm_sel", 32'(imm_sel), 32'(IMM_SEL_S));
    step(); step(); #1;
    chk_s("sw mem strobes", 9'b001110001);
    step(); dmem_ready = 1'b0; #1;
    chk_st("sw back to fetch", ST_FETCH);

    // bge taken/not taken, bgeu unsigned, beq taken
    run_fetch(INST_BGE);
    chk("bge decode imm_sel", 32'(imm_sel), 32'(IMM_SEL_B));
    step(); br_lt = 1'b1; #1;
    chk_s("bge lt=1 not taken", 9'b000010001);
    chk("bge br_un", 32'(br_un), 32'd0);
    chk("bge a_sel", 32'(a_sel), 32'd1);
    step(); #1;
    chk_st("bge back to fetch", ST_FETCH);
    run_fetch(INST_BGE);
    step(); br_lt = 1'b0; #1;
    chk_s("bge lt=0 taken", 9'b000011001);
    step();
    run_fetch(INST_BGEU);
    step(); #1;
    chk("bgeu br_un", 32'(br_un), 32'd1);
    chk_s("bgeu taken", 9'b000011001);
    step();
    run_fetch(INST_BEQ);
    step(); br_eq = 1'b1; #1;
    chk_s("beq eq taken", 9'b000011001);
    step(); br_eq = 1'b0;

    // jal x1
    run_fetch(INST_JAL);
    chk("jal decode imm_sel", 32'(imm_sel), 32'(IMM_SEL_J));
    step(); #1;
    chk("jal exec a_sel", 32'(a_sel), 32'd1);
    step(); #1;
    chk_s("jal wb strobes", 9'b000011101);
    chk("jal wb_sel", 32'(wb_sel), 32'(WB_SEL_PC4));
    step();

    // illegal encoding traps after DECODE and stays there
    run_fetch(INST_BAD);
    chk_s("illegal decode", 9'b000000001);
    step(); imem_ready = 1'b1; #1;
    chk_st("trap state", ST_TRAP);
    chk_s("trap strobes", 9'b000000010);
    step(); step(); #1;
    chk_s("trap held", 9'b000000010);
    reset_n = 1'b0; #1;
    chk_s("trap during reset", 9'b000000000);
    step(); reset_n = 1'b1; imem_ready = 1'b0; #1;
    chk_st("trap reset to fetch", ST_FETCH);
    chk_s("trap reset fetch strobes", 9'b100000000);

    // reset while a load is waiting in MEM
    run_fetch(INST_LW);
    step(); step(); #1;
    chk_s("mem before reset", 9'b001000001);
    reset_n = 1'b0;
    step(); #1;
    chk_s("outputs in reset", 9'b000000000);
    chk_st("reset from mem", ST_FETCH);
    reset_n = 1'b1; #1;
    chk_s("fetch after mem reset", 9'b100000000);

`ifdef CTRL_INSTRET_EN
    chk("instret after reset", instret, 32'd0);
    for (int k = 0; k < 10; k++) begin
      run_fetch(INST_ADD);
      step(); step(); step();
    end
    #1;
    chk("instret after 10", instret, 32'd10);
    chk("pc_write pulses after 10", 32'(pw_count), 32'd10);
`endif

    chk("imem/dmem exclusive", 32'(both_req), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
